// File: rtl/wb_module.sv
`default_nettype none
// ============================================================================
// wb_module : writeback stage - selects load/ALU data, owns the 8x16 register
//             file with write-through read ports, and counts retirements.
// Revision   : 1.0
// ============================================================================
module wb_module #(
   parameter logic [3:0] LOAD_OP  = 4'b1010,
   parameter logic [3:0] STORE_OP = 4'b1011
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [39:0] membus,
   input  logic [2:0]  raddr1,
   input  logic [2:0]  raddr2,
   output logic [15:0] rdata1,
   output logic [15:0] rdata2,
   output logic [2:0]  wb_dest,
   output logic [15:0] retire_count
);

   logic        valid;
   logic [3:0]  op;
   logic [2:0]  dest;
   logic [15:0] exresult;
   logic [15:0] memresult;
   logic        wen;
   logic [15:0] wdata;
   logic [15:0] regs [0:7];
   logic [15:0] count;

   assign valid     = membus[39];
   assign op        = membus[38:35];
   assign dest      = membus[34:32];
   assign exresult  = membus[31:16];
   assign memresult = membus[15:0];

   // Control-class ops (11xx), stores and r0 targets never write.
   assign wen   = valid && (op != STORE_OP) && (op[3:2] != 2'b11) && (dest != 3'b000);
   assign wdata = (op == LOAD_OP) ? memresult : exresult;

   assign regs[0] = 16'h0000;

   generate
      for (genvar gi = 1; gi < 8; gi++) begin : g_reg
         always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
               regs[gi] <= 16'h0000;
            end else if (wen && (dest == 3'(gi))) begin
               regs[gi] <= wdata;
            end
         end
      end
   endgenerate

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         count <= 16'h0000;
      end else if (valid) begin
         count <= count + 16'h0001;
      end
   end

   // dest is nonzero whenever wen is set, so r0 can never be bypassed.
   always_comb begin
      rdata1 = regs[raddr1];
      rdata2 = regs[raddr2];
      if (wen && (raddr1 == dest)) begin
         rdata1 = wdata;
      end
      if (wen && (raddr2 == dest)) begin
         rdata2 = wdata;
      end
   end

   assign wb_dest      = wen ? dest : 3'b000;
   assign retire_count = count;

endmodule
`default_nettype wire

// File: tb/tb_wb_module.sv
`default_nettype none
// ============================================================================
// tb_wb_module : directed self-checking bench for wb_module.
// Revision     : 1.0
// ============================================================================
module tb_wb_module;

   logic        clock;
   logic        resetn;
   logic [39:0] membus;
   logic [2:0]  raddr1;
   logic [2:0]  raddr2;
   logic [15:0] rdata1;
   logic [15:0] rdata2;
   logic [2:0]  wb_dest;
   logic [15:0] retire_count;

   int compared = 0;
   int mismatched = 0;

   wb_module dut (
      .clock        (clock),
      .resetn       (resetn),
      .membus       (membus),
      .raddr1       (raddr1),
      .raddr2       (raddr2),
      .rdata1       (rdata1),
      .rdata2       (rdata2),
      .wb_dest      (wb_dest),
      .retire_count (retire_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] o, input logic [2:0] d,
                        input logic [15:0] ex, input logic [15:0] mem);
      membus = {v, o, d, ex, mem};
      #1;
   endtask

   // Advance through one rising edge and return at the following falling edge.
   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      resetn = 1'b0;
      membus = '0;
      raddr1 = 3'd0;
      raddr2 = 3'd0;
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      #1;
      chk("reset_count", retire_count, 16'h0000);
      chk("reset_wbdest", {13'd0, wb_dest}, 16'h0000);

      // Preload r3, then reset asynchronously mid-cycle.
      @(negedge clock);
      raddr1 = 3'd3;
      drive(1'b1, 4'b0001, 3'd3, 16'h1234, 16'h0000);
      chk("r3_bypass", rdata1, 16'h1234);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("r3_stored", rdata1, 16'h1234);
      chk("r3_count", retire_count, 16'h0001);
      resetn = 1'b0;
      #1;
      chk("async_reset_r3", rdata1, 16'h0000);
      chk("async_reset_count", retire_count, 16'h0000);

      // A write presented while reset is held is lost.
      @(negedge clock);
      raddr1 = 3'd4;
      drive(1'b1, 4'b0001, 3'd4, 16'h5555, 16'h0000);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("reset_write_lost", rdata1, 16'h0000);
      chk("reset_hold_count", retire_count, 16'h0000);
      resetn = 1'b1;
      #1;

      // ALU writeback.
      @(negedge clock);
      raddr1 = 3'd5;
      drive(1'b1, 4'b0001, 3'd5, 16'hBEEF, 16'h1111);
      chk("alu_bypass", rdata1, 16'hBEEF);
      chk("alu_wbdest", {13'd0, wb_dest}, 16'h0005);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("alu_stored", rdata1, 16'hBEEF);
      chk("alu_count", retire_count, 16'h0001);

      // Load selects memresult.
      raddr2 = 3'd2;
      drive(1'b1, 4'b1010, 3'd2, 16'h0040, 16'hCAFE);
      chk("load_bypass", rdata2, 16'hCAFE);
      chk("load_wbdest", {13'd0, wb_dest}, 16'h0002);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("load_stored", rdata2, 16'hCAFE);
      chk("load_count", retire_count, 16'h0002);

      // Preload r4 so the non-writers have something to disturb.
      raddr1 = 3'd4;
      drive(1'b1, 4'b0010, 3'd4, 16'h4444, 16'h0000);
      step();
      drive(1'b1, 4'b1011, 3'd4, 16'h7777, 16'h8888);
      chk("store_no_bypass", rdata1, 16'h4444);
      chk("store_wbdest", {13'd0, wb_dest}, 16'h0000);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("store_r4", rdata1, 16'h4444);
      chk("store_count", retire_count, 16'h0004);

      drive(1'b1, 4'b1110, 3'd4, 16'h9999, 16'h9999);
      chk("ctrl_no_bypass", rdata1, 16'h4444);
      chk("ctrl_wbdest", {13'd0, wb_dest}, 16'h0000);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("ctrl_r4", rdata1, 16'h4444);
      chk("ctrl_count", retire_count, 16'h0005);

      // Invalid entry: nothing happens.
      raddr1 = 3'd6;
      drive(1'b0, 4'b0001, 3'd6, 16'h6666, 16'h0000);
      chk("invalid_no_bypass", rdata1, 16'h0000);
      chk("invalid_wbdest", {13'd0, wb_dest}, 16'h0000);
      step();
      chk("invalid_r6", rdata1, 16'h0000);
      chk("invalid_count", retire_count, 16'h0005);

      // r0 protection.
      raddr1 = 3'd0;
      raddr2 = 3'd0;
      drive(1'b1, 4'b0001, 3'd0, 16'hFFFF, 16'h0000);
      chk("r0_port1", rdata1, 16'h0000);
      chk("r0_port2", rdata2, 16'h0000);
      chk("r0_wbdest", {13'd0, wb_dest}, 16'h0000);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("r0_after", rdata1, 16'h0000);
      chk("r0_count", retire_count, 16'h0006);

      // Both ports bypass the same register.
      raddr1 = 3'd1;
      raddr2 = 3'd1;
      drive(1'b1, 4'b0001, 3'd1, 16'hA5A5, 16'h0000);
      chk("dual_bypass1", rdata1, 16'hA5A5);
      chk("dual_bypass2", rdata2, 16'hA5A5);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("dual_stored", rdata2, 16'hA5A5);
      chk("dual_count", retire_count, 16'h0007);

      // Counter wrap: run up to 16'hFFFF with stores, then one more.
      drive(1'b1, 4'b1011, 3'd0, 16'h0000, 16'h0000);
      for (int i = 0; i < 65528; i++) begin
         step();
      end
      chk("count_max", retire_count, 16'hFFFF);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("count_wrap", retire_count, 16'h0000);

      // Back-to-back writes to r7.
      raddr1 = 3'd7;
      raddr2 = 3'd7;
      drive(1'b1, 4'b0001, 3'd7, 16'h0001, 16'h0000);
      chk("r7_bypass_first", rdata1, 16'h0001);
      step();
      drive(1'b1, 4'b0001, 3'd7, 16'h0002, 16'h0000);
      chk("r7_bypass_second", rdata2, 16'h0002);
      step();
      drive(1'b0, 4'b0000, 3'd0, 16'h0000, 16'h0000);
      chk("r7_stored", rdata1, 16'h0002);
      chk("r7_count", retire_count, 16'h0002);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
